spi_cfg_master: RTL and testbench

SPI_CFG_MASTER -- requirements
Module: spi_cfg_master

---
 rtl/spi_cfg_pkg.sv | 31 +++
 rtl/spi_cfg_rr_arb.sv | 32 +++
 rtl/spi_cfg_master.sv | 168 ++++++++++++++++
 tb/tb_spi_cfg_master.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_cfg_pkg.sv
// Shared definitions for the SPI configuration master: register map, frame format, FSM states.
// No logic; make_frame builds the 16-bit write frame {1'b1, addr, data}, MSB sent first.
// Imported by spi_cfg_master.
package spi_cfg_pkg;

  localparam int FRAME_W = 16;

  // Target register map
  localparam logic [6:0] ADDR_OUT_7_0   = 7'h00;
  localparam logic [6:0] ADDR_OUT_15_8  = 7'h01;
  localparam logic [6:0] ADDR_PWM_7_0   = 7'h02;
  localparam logic [6:0] ADDR_PWM_15_8  = 7'h03;
  localparam logic [6:0] ADDR_PWM_DUTY  = 7'h04;
  localparam logic [6:0] ADDR_MAX       = ADDR_PWM_DUTY;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_HI,
    SHIFT_LO,
    HOLD,
    GAP
  } state_t;

  // Leading 1 marks the frame as a write.
  function automatic logic [FRAME_W-1:0] make_frame(input logic [6:0] addr,
                                                   input logic [7:0] data);
    return {1'b1, addr, data};
  endfunction

endpackage

// File: rtl/spi_cfg_rr_arb.sv
// Two-way round-robin grant between requesters A and B.
// Grants are combinational; the pointer updates one cycle after an acceptance.
// A requester that is not granted simply waits; no state is kept for it.
module spi_cfg_rr_arb (
  input  logic clk,
  input  logic rst_n,
  input  logic a_valid,
  input  logic b_valid,
  input  logic a_take,
  input  logic b_take,
  output logic gnt_a,
  output logic gnt_b
);

  // 1 when A was served last, so B wins the next tie.
  logic prefer_b;

  // Move the pointer away from whichever requester was just accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prefer_b <= 1'b0;
    end else if (a_take) begin
      prefer_b <= 1'b1;
    end else if (b_take) begin
      prefer_b <= 1'b0;
    end
  end

  assign gnt_a = a_valid && (!b_valid || !prefer_b);
  assign gnt_b = b_valid && (!a_valid || prefer_b);

endmodule

// File: rtl/spi_cfg_master.sv
// SPI write-only configuration master for two requesters; frames are {1, addr[6:0], data[7:0]}.
// nCS falls the cycle after acceptance and stays low 34*CLK_DIV cycles, then a 2*CLK_DIV gap.
// Ready is offered only in IDLE; SPI_CFG_ADDR_CHECK_EN rejects addr > ADDR_MAX with an err pulse.
module spi_cfg_master
  import spi_cfg_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a_valid,
  output logic       a_ready,
  input  logic [6:0] a_addr,
  input  logic [7:0] a_data,
  input  logic       b_valid,
  output logic       b_ready,
  input  logic [6:0] b_addr,
  input  logic [7:0] b_data,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       SCLK,
  output logic       nCS,
  output logic       COPI
);

  localparam int              DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [4:0]      LAST_BIT = 5'(FRAME_W - 1);

  state_t             state, state_nxt;
  logic [DIV_W-1:0]   div_cnt, div_nxt, div_inc;
  logic [4:0]         bit_cnt, bit_nxt;
  logic [FRAME_W-1:0] shreg, sh_nxt;
  logic               err_q, err_nxt;

  logic       gnt_a, gnt_b;
  logic       idle, div_last, frame_active;
  logic       acc_a, acc_b, acc;
  logic [6:0] acc_addr;
  logic [7:0] acc_data;
  logic       bad_addr;

  spi_cfg_rr_arb u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_valid (a_valid),
    .b_valid (b_valid),
    .a_take  (acc_a),
    .b_take  (acc_b),
    .gnt_a   (gnt_a),
    .gnt_b   (gnt_b)
  );

  assign idle = (state == IDLE);

  // rst_n gate keeps ready low while reset is held even though state already reads IDLE.
  assign a_ready = rst_n && idle && gnt_a;
  assign b_ready = rst_n && idle && gnt_b;

  assign acc_a    = a_valid && a_ready;
  assign acc_b    = b_valid && b_ready;
  assign acc      = acc_a || acc_b;
  assign acc_addr = acc_a ? a_addr : b_addr;
  assign acc_data = acc_a ? a_data : b_data;

`ifdef SPI_CFG_ADDR_CHECK_EN
  assign bad_addr = (acc_addr > ADDR_MAX);
`else
  assign bad_addr = 1'b0;
`endif

  assign div_last = (div_cnt == DIV_LAST);
  assign div_inc  = div_last ? '0 : div_cnt + DIV_W'(1);

  // Next-state, counter and shift-register update for the frame sequencer.
  always_comb begin
    state_nxt = state;
    div_nxt   = '0;
    bit_nxt   = bit_cnt;
    sh_nxt    = shreg;
    err_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        bit_nxt = '0;
        if (acc) begin
          if (bad_addr) begin
            // Handshake completes but nothing is sent; stay in IDLE.
            err_nxt = 1'b1;
          end else begin
            state_nxt = SETUP;
            sh_nxt    = make_frame(acc_addr, acc_data);
          end
        end
      end
      SETUP: begin
        div_nxt = div_inc;
        if (div_last) state_nxt = SHIFT_HI;
      end
      SHIFT_HI: begin
        div_nxt = div_inc;
        if (div_last) begin
          // Next bit appears on COPI as SCLK falls.
          state_nxt = SHIFT_LO;
          sh_nxt    = {shreg[FRAME_W-2:0], 1'b0};
        end
      end
      SHIFT_LO: begin
        div_nxt = div_inc;
        if (div_last) begin
          if (bit_cnt == LAST_BIT) begin
            state_nxt = HOLD;
            bit_nxt   = '0;
          end else begin
            state_nxt = SHIFT_HI;
            bit_nxt   = bit_cnt + 5'd1;
          end
        end
      end
      HOLD: begin
        div_nxt = div_inc;
        if (div_last) state_nxt = GAP;
      end
      GAP: begin
        // Gap spans two divider periods; bit_cnt counts them.
        div_nxt = div_inc;
        if (div_last) begin
          if (bit_cnt == 5'd1) begin
            state_nxt = IDLE;
            bit_nxt   = '0;
          end else begin
            bit_nxt = bit_cnt + 5'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counters, frame shift register and err pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      div_cnt <= div_nxt;
      bit_cnt <= bit_nxt;
      shreg   <= sh_nxt;
      err_q   <= err_nxt;
    end
  end

  assign frame_active = (state == SETUP) || (state == SHIFT_HI) ||
                        (state == SHIFT_LO) || (state == HOLD);

  assign SCLK = (state == SHIFT_HI);
  assign nCS  = !frame_active;
  assign COPI = frame_active && shreg[FRAME_W-1];
  assign busy = !idle;
  // First cycle of GAP is the cycle right after HOLD exits.
  assign done = (state == GAP) && (bit_cnt == 5'd0) && (div_cnt == '0);
  assign err  = err_q;

endmodule

// File: tb/tb_spi_cfg_master.sv
// Directed bench for spi_cfg_master at CLK_DIV=4.
// Inputs change on the falling edge; outputs are checked on the falling edge or 1ns after it.
// A posedge monitor keeps running totals; each step compares deltas against hand values.
module tb_spi_cfg_master;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_valid, b_valid;
  logic       a_ready, b_ready;
  logic [6:0] a_addr, b_addr;
  logic [7:0] a_data, b_data;
  logic       busy, done, err, SCLK, nCS, COPI;

  int checks = 0;
  int errors = 0;

  spi_cfg_master #(.CLK_DIV(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .a_addr  (a_addr),
    .a_data  (a_data),
    .b_valid (b_valid),
    .b_ready (b_ready),
    .b_addr  (b_addr),
    .b_data  (b_data),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .SCLK    (SCLK),
    .nCS     (nCS),
    .COPI    (COPI)
  );

  always #5 clk = ~clk;

  // Running totals sampled at each rising clk edge (pre-edge values).
  int cyc = 0, ncs_lo_total = 0, done_total = 0, err_total = 0;
  int acc_a_total = 0, acc_b_total = 0, done_cyc = 0, acc_b_cyc = 0;
  int hi_run = 0, hi_busy = 0, last_gap = 0, last_gap_busy = 0;
  always @(posedge clk) begin
    cyc++;
    if (!nCS) begin
      ncs_lo_total++;
      if (hi_run != 0) begin
        last_gap      = hi_run;
        last_gap_busy = hi_busy;
      end
      hi_run  = 0;
      hi_busy = 0;
    end else begin
      hi_run++;
      if (busy) hi_busy++;
    end
    if (done) begin
      done_total++;
      done_cyc = cyc;
    end
    if (err) err_total++;
    if (a_valid && a_ready) acc_a_total++;
    if (b_valid && b_ready) begin
      acc_b_total++;
      acc_b_cyc = cyc;
    end
  end

  // Bits as the target would see them on SCLK rising edges.
  int          rx_total = 0;
  logic [15:0] rx = '0;
  always @(posedge SCLK) begin
    rx = {rx[14:0], COPI};
    rx_total++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, busy, 0);
  endtask

  initial begin
    int d0, n0, e0, r0, aa0, ab0, c;

    // ---- reset state, with A already requesting ----
    rst_n = 1'b0;
    a_valid = 1'b1; a_addr = 7'h00; a_data = 8'h00;
    b_valid = 1'b0; b_addr = 7'h00; b_data = 8'h00;
    #1;
    check("rst_ncs", nCS, 1);
    check("rst_sclk", SCLK, 0);
    check("rst_copi", COPI, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_a_ready", a_ready, 0);
    check("rst_b_ready", b_ready, 0);
    repeat (2) @(negedge clk);
    a_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // ---- single write A: addr 0x04 data 0xA5 -> 16'h84A5 ----
    d0 = done_total; n0 = ncs_lo_total; e0 = err_total; r0 = rx_total;
    a_addr = 7'h04; a_data = 8'hA5; a_valid = 1'b1;
    #1;
    check("t1_a_ready", a_ready, 1);
    check("t1_b_ready", b_ready, 0);
    @(negedge clk);
    a_valid = 1'b0;
    check("t1_ncs_T1", nCS, 0);
    check("t1_busy_T1", busy, 1);
    check("t1_copi_bit15", COPI, 1);
    check("t1_sclk_setup", SCLK, 0);
    wait_idle("t1_idle_timeout", 400);
    check("t1_ncs_low_cycles", ncs_lo_total - n0, 136);
    check("t1_done_pulses", done_total - d0, 1);
    check("t1_sclk_rises", rx_total - r0, 16);
    check("t1_rx_frame", rx, 16'h84A5);
    check("t1_no_err", err_total - e0, 0);

    // ---- simultaneous A and B after reset: A first, B in first IDLE after GAP ----
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    d0 = done_total; ab0 = acc_b_total;
    a_addr = 7'h01; a_data = 8'h5A; a_valid = 1'b1;
    b_addr = 7'h03; b_data = 8'hC3; b_valid = 1'b1;
    #1;
    check("t2_a_first", a_ready, 1);
    check("t2_b_waits", b_ready, 0);
    @(negedge clk);
    a_valid = 1'b0;
    #1;
    check("t2_b_no_ready_busy", b_ready, 0);
    c = 0;
    while (acc_b_total == ab0 && c < 600) begin
      @(negedge clk);
      c++;
    end
    b_valid = 1'b0;
    check("t2_b_accepted", acc_b_total - ab0, 1);
    check("t2_b_after_gap", acc_b_cyc - done_cyc, 8);
    wait_idle("t2_idle_timeout", 400);
    check("t2_done_pulses", done_total - d0, 2);
    check("t2_rx_frame_b", rx, 16'h83C3);

    // ---- B continuous, A rises mid-frame: A wins next ----
    @(negedge clk);
    d0 = done_total; aa0 = acc_a_total; ab0 = acc_b_total;
    b_addr = 7'h00; b_data = 8'h0F; b_valid = 1'b1;
    #1;
    check("t3_b_ready_alone", b_ready, 1);
    check("t3_a_ready_alone", a_ready, 0);
    @(negedge clk);
    repeat (40) @(negedge clk);
    a_addr = 7'h02; a_data = 8'h77; a_valid = 1'b1;
    #1;
    check("t3_a_no_ready_midframe", a_ready, 0);
    c = 0;
    while (!(a_ready || b_ready) && c < 400) begin
      @(negedge clk);
      #1;
      c++;
    end
    check("t3_a_granted", a_ready, 1);
    check("t3_b_not_granted", b_ready, 0);
    @(negedge clk);
    a_valid = 1'b0;
    b_valid = 1'b0;
    wait_idle("t3_idle_timeout", 400);
    repeat (5) @(negedge clk);
    check("t3_b_dropped_no_frame", busy, 0);
    check("t3_done_pulses", done_total - d0, 2);
    check("t3_acc_a", acc_a_total - aa0, 1);
    check("t3_acc_b", acc_b_total - ab0, 1);
    check("t3_rx_frame_a", rx, 16'h8277);

    // ---- reset during bit 7, then a clean frame ----
    d0 = done_total; r0 = rx_total;
    a_addr = 7'h03; a_data = 8'hFF; a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    c = 0;
    while ((rx_total - r0) < 9 && c < 400) begin
      @(negedge clk);
      c++;
    end
    check("t4_reached_bit7", rx_total - r0, 9);
    rst_n = 1'b0;
    #1;
    check("t4_rst_ncs", nCS, 1);
    check("t4_rst_sclk", SCLK, 0);
    check("t4_rst_copi", COPI, 0);
    check("t4_rst_busy", busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("t4_no_done", done_total - d0, 0);
    check("t4_no_retransmit", nCS, 1);
    d0 = done_total; n0 = ncs_lo_total;
    a_addr = 7'h02; a_data = 8'h3C; a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    wait_idle("t4_idle_timeout", 400);
    check("t4_done_after", done_total - d0, 1);
    check("t4_ncs_low_cycles", ncs_lo_total - n0, 136);
    check("t4_rx_frame", rx, 16'h823C);

    // ---- out-of-map address 0x05 ----
    @(negedge clk);
    d0 = done_total; n0 = ncs_lo_total; e0 = err_total;
    a_addr = 7'h05; a_data = 8'h11; a_valid = 1'b1;
    #1;
    check("t5_a_ready", a_ready, 1);
    @(negedge clk);
    a_valid = 1'b0;
`ifdef SPI_CFG_ADDR_CHECK_EN
    check("t5_err_T1", err, 1);
    check("t5_ncs_high", nCS, 1);
    check("t5_busy_low", busy, 0);
    @(negedge clk);
    check("t5_err_one_cycle", err, 0);
    repeat (10) @(negedge clk);
    check("t5_no_done", done_total - d0, 0);
    check("t5_err_pulses", err_total - e0, 1);
    check("t5_no_ncs_low", ncs_lo_total - n0, 0);
`else
    check("t5_err_T1", err, 0);
    check("t5_ncs_low", nCS, 0);
    wait_idle("t5_idle_timeout", 400);
    check("t5_done", done_total - d0, 1);
    check("t5_err_pulses", err_total - e0, 0);
    check("t5_rx_frame", rx, 16'h8511);
`endif

    // ---- back-to-back writes from A ----
    @(negedge clk);
    d0 = done_total; n0 = ncs_lo_total; aa0 = acc_a_total;
    a_addr = 7'h00; a_data = 8'h55; a_valid = 1'b1;
    c = 0;
    while ((acc_a_total - aa0) < 2 && c < 800) begin
      @(negedge clk);
      c++;
    end
    a_valid = 1'b0;
    check("t6_two_accepts", acc_a_total - aa0, 2);
    wait_idle("t6_idle_timeout", 400);
    check("t6_done_pulses", done_total - d0, 2);
    check("t6_ncs_low_cycles", ncs_lo_total - n0, 272);
    check("t6_gap_ge8", last_gap >= 8, 1);
    check("t6_busy_through_gap", last_gap_busy, 8);
    check("t6_rx_frame", rx, 16'h8055);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
